// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the load/store
// port (port 0) and the program/debug loader (port 1). Round-robin grant
// with an optional burst lock that a waiting port can break after MAX_LOCK
// consecutive locked grants. Read data returns one cycle after acceptance.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic          req0_lock,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic          req1_lock,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

  // arbitration state: last granted port doubles as the current owner
  logic          last_r;
  logic          owner_locked_r;
  logic [3:0]    lock_cnt_r;

  // read response registers
  logic          rvalid0_r;
  logic          rvalid1_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;

  // arbitration result and winner's request fields
  logic          owner_req_s;
  logic          other_req_s;
  logic          grant_s;
  logic          win_s;
  logic          win_we_s;
  logic          win_lock_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_wdata_s;
  logic          continue_lock_s;
  logic [3:0]    lock_cnt_next_s;

  // pick the winner: locked owner, then forced switch, then round-robin
  always_comb begin
    owner_req_s = last_r ? req1_valid : req0_valid;
    other_req_s = last_r ? req0_valid : req1_valid;
    grant_s     = 1'b0;
    win_s       = last_r;
    if (!reset) begin
      grant_s = 1'b0;
      win_s   = last_r;
    end else if (owner_locked_r && owner_req_s && (lock_cnt_r < LOCK_MAX)) begin
      grant_s = 1'b1;
      win_s   = last_r;
    end else if (owner_locked_r && (lock_cnt_r == LOCK_MAX) && other_req_s) begin
      // lock budget spent while the other port waits: hand over
      grant_s = 1'b1;
      win_s   = ~last_r;
    end else if (other_req_s) begin
      grant_s = 1'b1;
      win_s   = ~last_r;
    end else if (owner_req_s) begin
      grant_s = 1'b1;
      win_s   = last_r;
    end else begin
      grant_s = 1'b0;
      win_s   = last_r;
    end
  end

  // route the winner's request fields and compute the next lock count
  always_comb begin
    win_we_s        = win_s ? req1_we    : req0_we;
    win_lock_s      = win_s ? req1_lock  : req0_lock;
    win_addr_s      = win_s ? req1_addr  : req0_addr;
    win_wdata_s     = win_s ? req1_wdata : req0_wdata;
    continue_lock_s = owner_locked_r && (win_s == last_r) && win_lock_s;
    lock_cnt_next_s = 4'd0;
    if (!continue_lock_s) begin
      lock_cnt_next_s = 4'd0;
    end else if (lock_cnt_r >= LOCK_MAX) begin
      lock_cnt_next_s = LOCK_MAX;
    end else begin
      lock_cnt_next_s = lock_cnt_r + 4'd1;
    end
  end

  // memory side and ready strobes follow the grant in the same cycle
  always_comb begin
    req0_ready = grant_s && !win_s;
    req1_ready = grant_s && win_s;
    if (grant_s) begin
      mem_we    = win_we_s;
      mem_addr  = win_addr_s;
      mem_wdata = win_wdata_s;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
    end
  end

  // arbitration state update; an idle cycle means the owner dropped valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_r         <= 1'b1;
      owner_locked_r <= 1'b0;
      lock_cnt_r     <= 4'd0;
    end else if (grant_s) begin
      last_r         <= win_s;
      owner_locked_r <= win_lock_s;
      lock_cnt_r     <= lock_cnt_next_s;
    end else begin
      owner_locked_r <= 1'b0;
      lock_cnt_r     <= 4'd0;
    end
  end

  // capture read data on acceptance; rvalid is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= {DW{1'b0}};
      rdata1_r  <= {DW{1'b0}};
    end else begin
      rvalid0_r <= grant_s && !win_s && !win_we_s;
      rvalid1_r <= grant_s && win_s && !win_we_s;
      if (grant_s && !win_s && !win_we_s) begin
        rdata0_r <= mem_rdata;
      end else begin
        rdata0_r <= rdata0_r;
      end
      if (grant_s && win_s && !win_we_s) begin
        rdata1_r <= mem_rdata;
      end else begin
        rdata1_r <= rdata1_r;
      end
    end
  end

  assign req0_rvalid = rvalid0_r;
  assign req1_rvalid = rvalid1_r;
  assign req0_rdata  = rdata0_r;
  assign req1_rdata  = rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, a few hand sequences and a
// randomized run, all checked against a rule-level reference model.
module tb_dmem_arbiter;

  localparam int MAX_LOCK = 4;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] P1 = 32'h12345678;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_we, req0_lock, req0_ready, req0_rvalid;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_we, req1_lock, req1_ready, req1_rvalid;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        env_clear;
  logic [31:0] dmem [64];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          rst;
    bit          v0, we0, lk0;
    logic [31:0] a0, d0;
    bit          v1, we1, lk1;
    logic [31:0] a1, d1;
    bit          e_rdy0, e_rdy1, e_we;
    logic [31:0] e_addr;
    bit          e_rv0;
    logic [31:0] e_rd0;
    bit          e_rv1;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t tbl [29];

  // reference model state
  logic [31:0] ref_mem [64];
  int          m_last;
  bit          m_locked;
  int          m_cnt;
  bit          m_rv [2];
  logic [31:0] m_rd [2];

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // clock
  always #5 clk = ~clk;

  // data memory: combinational read, write on the rising edge
  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (env_clear) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
    end else if (mem_we) begin
      dmem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // one clock cycle: drive, compare against model (and table), advance model
  task automatic do_cycle(input vec_t v, input bit use_tbl);
    int          w;
    bit          rq [2];
    bit          we [2];
    bit          lk [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    @(negedge clk);
    cyc++;
    reset = v.rst;
    req0_valid = v.v0; req0_we = v.we0; req0_lock = v.lk0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_we = v.we1; req1_lock = v.lk1; req1_addr = v.a1; req1_wdata = v.d1;
    #1;
    rq[0] = v.v0;  rq[1] = v.v1;
    we[0] = v.we0; we[1] = v.we1;
    lk[0] = v.lk0; lk[1] = v.lk1;
    ad[0] = v.a0;  ad[1] = v.a1;
    wd[0] = v.d0;  wd[1] = v.d1;
    w = -1;
    if (v.rst) begin
      if (m_locked && rq[m_last] && m_cnt < MAX_LOCK) w = m_last;
      else if (rq[1 - m_last]) w = 1 - m_last;
      else if (rq[m_last]) w = m_last;
    end
    chk("m_ready0", {31'h0, req0_ready}, {31'h0, w == 0});
    chk("m_ready1", {31'h0, req1_ready}, {31'h0, w == 1});
    chk("m_mem_we", {31'h0, mem_we}, (w >= 0) ? {31'h0, we[w]} : 32'h0);
    chk("m_mem_addr", mem_addr, (w >= 0) ? ad[w] : 32'h0);
    chk("m_mem_wdata", mem_wdata, (w >= 0) ? wd[w] : 32'h0);
    if (v.rst) begin
      chk("m_rvalid0", {31'h0, req0_rvalid}, {31'h0, m_rv[0]});
      chk("m_rvalid1", {31'h0, req1_rvalid}, {31'h0, m_rv[1]});
      chk("m_rdata0", req0_rdata, m_rd[0]);
      chk("m_rdata1", req1_rdata, m_rd[1]);
    end
    if (use_tbl) begin
      chk("t_ready0", {31'h0, req0_ready}, {31'h0, v.e_rdy0});
      chk("t_ready1", {31'h0, req1_ready}, {31'h0, v.e_rdy1});
      chk("t_mem_we", {31'h0, mem_we}, {31'h0, v.e_we});
      chk("t_mem_addr", mem_addr, v.e_addr);
      if (v.rst) begin
        chk("t_rvalid0", {31'h0, req0_rvalid}, {31'h0, v.e_rv0});
        chk("t_rdata0", req0_rdata, v.e_rd0);
        chk("t_rvalid1", {31'h0, req1_rvalid}, {31'h0, v.e_rv1});
        chk("t_rdata1", req1_rdata, v.e_rd1);
      end
    end
    // advance the model to the state after the coming rising edge
    if (!v.rst) begin
      m_last = 1; m_locked = 1'b0; m_cnt = 0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 32'h0; m_rd[1] = 32'h0;
    end else begin
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (w >= 0) begin
        if (we[w]) begin
          ref_mem[ad[w][7:2]] = wd[w];
        end else begin
          m_rd[w] = ref_mem[ad[w][7:2]];
          m_rv[w] = 1'b1;
        end
        if (m_locked && w == m_last && lk[w]) m_cnt = (m_cnt < MAX_LOCK) ? m_cnt + 1 : MAX_LOCK;
        else m_cnt = 0;
        m_locked = lk[w];
        m_last = w;
      end else begin
        m_locked = 1'b0;
        m_cnt = 0;
      end
    end
  endtask

  initial begin
    vec_t idle;
    vec_t r;
    idle = '{H, L,L,L,Z,Z, L,L,L,Z,Z, L,L,L,Z, L,Z,L,Z};

    //        rst v0 we lk a0     d0        v1 we lk a1     d1   | rdy0 rdy1 we addr    rv0 rd0 rv1 rd1
    tbl[0]  = '{L, H,H,L,32'h8,DB,        L,L,L,Z,Z,         L,L,L,Z,        L,Z,L,Z};
    tbl[1]  = '{H, H,H,L,32'h8,DB,        L,L,L,Z,Z,         H,L,H,32'h8,    L,Z,L,Z};
    tbl[2]  = '{H, H,L,L,32'hB,Z,         L,L,L,Z,Z,         H,L,L,32'hB,    L,Z,L,Z};
    tbl[3]  = '{H, L,L,L,Z,Z,             L,L,L,Z,Z,         L,L,L,Z,        H,DB,L,Z};
    tbl[4]  = '{H, L,L,L,Z,Z,             H,H,L,32'h4,P1,    L,H,H,32'h4,    L,DB,L,Z};
    tbl[5]  = '{H, H,L,L,32'h8,Z,         H,L,L,32'h4,Z,     H,L,L,32'h8,    L,DB,L,Z};
    tbl[6]  = '{H, H,L,L,32'h8,Z,         H,L,L,32'h4,Z,     L,H,L,32'h4,    H,DB,L,Z};
    tbl[7]  = '{H, H,L,L,32'h8,Z,         H,L,L,32'h4,Z,     H,L,L,32'h8,    L,DB,H,P1};
    tbl[8]  = '{H, H,L,L,32'h8,Z,         H,L,L,32'h4,Z,     L,H,L,32'h4,    H,DB,L,P1};
    tbl[9]  = '{H, L,L,L,Z,Z,             L,L,L,Z,Z,         L,L,L,Z,        L,DB,H,P1};
    tbl[10] = '{H, H,L,L,32'h8,Z,         H,L,H,32'h4,Z,     H,L,L,32'h8,    L,DB,L,P1};
    tbl[11] = '{H, H,L,L,32'h8,Z,         H,L,H,32'h4,Z,     L,H,L,32'h4,    H,DB,L,P1};
    tbl[12] = '{H, H,L,L,32'h8,Z,         H,L,H,32'h4,Z,     L,H,L,32'h4,    L,DB,H,P1};
    tbl[13] = '{H, H,L,L,32'h8,Z,         H,L,H,32'h4,Z,     L,H,L,32'h4,    L,DB,H,P1};
    tbl[14] = '{H, H,L,L,32'h8,Z,         H,L,H,32'h4,Z,     L,H,L,32'h4,    L,DB,H,P1};
    tbl[15] = '{H, H,L,L,32'h8,Z,         H,L,H,32'h4,Z,     L,H,L,32'h4,    L,DB,H,P1};
    tbl[16] = '{H, H,L,L,32'h8,Z,         H,L,H,32'h4,Z,     H,L,L,32'h8,    L,DB,H,P1};
    tbl[17] = '{H, H,L,L,32'h8,Z,         H,L,H,32'h4,Z,     L,H,L,32'h4,    H,DB,L,P1};
    tbl[18] = '{H, H,L,L,32'h8,Z,         H,L,H,32'h4,Z,     L,H,L,32'h4,    L,DB,H,P1};
    tbl[19] = '{H, L,L,L,Z,Z,             L,L,L,Z,Z,         L,L,L,Z,        L,DB,H,P1};
    tbl[20] = '{H, H,H,L,32'h10,32'h11,   H,L,L,32'h10,Z,    H,L,H,32'h10,   L,DB,L,P1};
    tbl[21] = '{H, L,L,L,Z,Z,             H,L,L,32'h10,Z,    L,H,L,32'h10,   L,DB,L,P1};
    tbl[22] = '{H, L,L,L,Z,Z,             L,L,L,Z,Z,         L,L,L,Z,        L,DB,H,32'h11};
    tbl[23] = '{H, L,L,L,Z,Z,             L,L,L,Z,Z,         L,L,L,Z,        L,DB,L,32'h11};
    tbl[24] = '{H, H,L,L,32'h10,Z,        L,L,L,Z,Z,         H,L,L,32'h10,   L,DB,L,32'h11};
    tbl[25] = '{L, H,L,L,32'h10,Z,        H,L,L,32'h4,Z,     L,L,L,Z,        L,Z,L,Z};
    tbl[26] = '{H, H,L,L,32'h4,Z,         H,L,L,32'h10,Z,    H,L,L,32'h4,    L,Z,L,Z};
    tbl[27] = '{H, H,L,L,32'h4,Z,         H,L,L,32'h10,Z,    L,H,L,32'h10,   H,P1,L,Z};
    tbl[28] = '{H, L,L,L,Z,Z,             L,L,L,Z,Z,         L,L,L,Z,        L,P1,H,32'h11};

    // initial reset with memory clear
    reset = 1'b0; env_clear = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_lock = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    m_last = 1; m_locked = 1'b0; m_cnt = 0;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 32'h0; m_rd[1] = 32'h0;
    @(posedge clk);
    #1 env_clear = 1'b0;

    // directed vector table
    for (int i = 0; i < 29; i++) do_cycle(tbl[i], 1'b1);

    // ten idle cycles: everything quiet
    for (int i = 0; i < 10; i++) begin
      do_cycle(idle, 1'b0);
      chk("idle_ready", {30'h0, req1_ready, req0_ready}, 32'h0);
      chk("idle_rvalid", {30'h0, req1_rvalid, req0_rvalid}, 32'h0);
      chk("idle_mem", {mem_addr[30:0], mem_we}, 32'h0);
    end

    // locked port 0 alone for 8 cycles keeps ownership; then port 1 breaks in at once
    r = '{H, H,L,H,32'h20,Z, L,L,L,Z,Z, L,L,L,Z, L,Z,L,Z};
    for (int i = 0; i < 8; i++) begin
      do_cycle(r, 1'b0);
      chk("solo_lock_ready0", {31'h0, req0_ready}, 32'h1);
    end
    r.v1 = 1'b1; r.a1 = 32'h24;
    do_cycle(r, 1'b0);
    chk("lock_sat_switch", {30'h0, req1_ready, req0_ready}, 32'h2);

    // randomized traffic: light locking, then heavy locking
    for (int seg = 0; seg < 2; seg++) begin
      for (int i = 0; i < 1500; i++) begin
        r.rst = ($urandom_range(0, 59) != 0);
        r.v0  = ($urandom_range(0, 9) < 7);
        r.we0 = ($urandom_range(0, 9) < 3);
        r.lk0 = (seg == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
        r.a0  = {24'h0, 8'($urandom_range(0, 255))};
        r.d0  = $urandom;
        r.v1  = ($urandom_range(0, 9) < 7);
        r.we1 = ($urandom_range(0, 9) < 3);
        r.lk1 = (seg == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 9);
        r.a1  = {24'h0, 8'($urandom_range(0, 255))};
        r.d1  = $urandom;
        do_cycle(r, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
